// File: rtl/fanout_fork_buffer.sv
// Single-entry buffered eager fork: holds one token and broadcasts it to
// every active branch, retiring it once each owed branch has handshaken.
module fanout_fork_buffer #(
  parameter int NUM_OUT = 9,
  parameter int DATA_W  = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_OUT-1:0] br_en,
  input  logic [NUM_OUT-1:0] br_sel,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [NUM_OUT-1:0] br_done,
  output logic [15:0]        xfer_cnt
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_OUT-1:0] pending_q, pending_d;
  logic [15:0]        xfer_cnt_q, xfer_cnt_d;

  logic [NUM_OUT-1:0] active;
  logic [NUM_OUT-1:0] hs;
  logic               full;
  logic               drain;
  logic               accept;
  logic               any_active;

  assign full       = (state_q == S_FULL);
  assign active     = br_en & br_sel;
  assign any_active = |active;
  assign out_valid  = {NUM_OUT{full}} & pending_q & active;
  assign hs         = out_valid & out_ready;
  assign br_done    = ~active | ~pending_q | out_ready;
  assign drain      = full & (&br_done);
  assign in_ready   = ~full | drain;
  assign accept     = in_valid & in_ready;
  assign out_data   = data_q;
  assign xfer_cnt   = xfer_cnt_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    pending_d  = pending_q;
    xfer_cnt_d = xfer_cnt_q;
    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          if (any_active) begin
            state_d   = S_FULL;
            data_d    = in_data;
            pending_d = active;
          end else begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
          end
        end
      end
      S_FULL: begin
        if (drain) begin
          if (accept && any_active) begin
            data_d     = in_data;
            pending_d  = active;
            xfer_cnt_d = xfer_cnt_q + 16'd1;
          end else if (accept) begin
            // held token retires and the consumer-less newcomer is dropped
            state_d    = S_EMPTY;
            pending_d  = '0;
            xfer_cnt_d = xfer_cnt_q + 16'd2;
          end else begin
            state_d    = S_EMPTY;
            pending_d  = '0;
            xfer_cnt_d = xfer_cnt_q + 16'd1;
          end
        end else begin
          pending_d = pending_q & ~hs & active;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      data_q     <= '0;
      pending_q  <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      pending_q  <= pending_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule

// File: doc/fanout_fork_buffer.md
Name: fanout_fork_buffer

Overview:
- Single-entry buffered eager fork that sits directly upstream of the fanout ready-merge.
- Accepts one valid/ready stream and broadcasts each token to up to NUM_OUT consumer branches.
- Tracks per-branch acceptance, so fast consumers never re-receive a token while slow ones are still pending.
- Produces the per-branch valids and "branch done" terms that the ready-merge combines. Also owns the aggregated upstream ready.

Parameters:
- NUM_OUT, 9, number of consumer branches.
- DATA_W, 17, stream token width (16 data bits + 1 control/stop bit).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  upstream token.
- in_valid  in  1  upstream token valid.
- in_ready  out  1  block can accept a token this cycle.
- br_en  in  NUM_OUT  per-branch tile enable.
- br_sel  in  NUM_OUT  per-branch config select; branch i is active when br_en[i] & br_sel[i].
- out_data  out  DATA_W  shared broadcast token (registered).
- out_valid  out  NUM_OUT  per-branch valid.
- out_ready  in  NUM_OUT  per-branch consumer ready.
- br_done  out  NUM_OUT  branch i has no outstanding obligation for the held token (~active[i] | ~pending[i] | out_ready[i]); this feeds the ready-merge.
- xfer_cnt  out  16  count of tokens fully retired (debug).

Behaviour:
- State: full (1 bit), data_q (DATA_W), pending (NUM_OUT), xfer_cnt (16). active = br_en & br_sel, combinational.
- Reset (synchronous): full=0, pending=0, data_q=0, xfer_cnt=0.
  - Resulting outputs during reset: out_valid=0, out_data=0, in_ready=1.
- Reset mid-operation drops the held token; no branch sees a further valid.
- out_valid[i] = full & pending[i] & active[i].
- out_data = data_q, held stable while full.
- Branch handshake: out_valid[i] & out_ready[i]. That branch's pending bit clears at the next edge.
- drain = full & (AND over i of br_done[i]). Every still-owed branch is retired this cycle or is already retired.
- in_ready = ~full | drain. This bypass gives throughput 1 token/cycle when all consumers are ready.
- Accept = in_valid & in_ready. Latency is 1 cycle: token is visible on out_valid the cycle after accept.
- FSM EMPTY (full=0) / FULL (full=1):
  - EMPTY & accept & (active != 0) -> FULL; data_q=in_data; pending=active.
  - EMPTY & accept & (active == 0) -> stay EMPTY. Token is discarded and xfer_cnt increments (no consumers).
  - FULL & drain & accept & (active != 0) -> stay FULL; load new token; pending=active; xfer_cnt+1.
  - FULL & drain & no accept -> EMPTY; pending=0; xfer_cnt+1.
  - FULL & no drain -> pending &= ~(out_valid & out_ready) & active.
- Config change while FULL: a branch whose active bit drops is treated as done. Its pending bit is cleared and it never gets the token.
  - A branch that becomes active while FULL is not owed the held token (pending is not set).
- Simultaneous last-branch handshake + new upstream token: both happen in the same cycle (bypass rule above). No bubble.
- xfer_cnt wraps 0xFFFF -> 0x0000.
- in_ready depends combinationally on out_ready/br_en/br_sel. There is no combinational path from in_valid to in_ready.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> out_valid=0, in_ready=1, xfer_cnt=0. in_valid=0 afterwards -> state unchanged.
- Broadcast all ready: active=0x1FF, all out_ready=1, send 0x00005, 0x00006, 0x10000 back-to-back.
  - Each appears on all 9 out_valid one cycle after accept.
  - in_ready stays 1 throughout; xfer_cnt=3.
- Staggered consumers: active=0x007, token 0x0ABC.
  - Branch0 ready at cycle 1, branch1 at cycle 3, branch2 at cycle 5.
  - Each branch's out_valid drops the cycle after its handshake.
  - in_ready=0 until cycle 5, then 1 with drain; no duplicate delivery.
- Zero active branches: br_sel=0, send 4 tokens -> all accepted at 1/cycle, out_valid never rises, xfer_cnt=4.
- Mid-token disable: active=0x003, token held, branch1 never ready. Deassert br_en[1] -> drain next cycle, in_ready=1, token retired via branch0 only.
- Reset mid-operation: FULL with pending=0x1F0, assert reset -> out_valid=0 next cycle, full=0. A new token after reset is delivered normally.
